rf_wr_arb: RTL and testbench

RF_WR_ARB -- requirements
Module: rf_wr_arb

---
 rtl/rf_wr_arb.sv | 206 ++++++++++++++++++++
 tb/tb_rf_wr_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arb.sv
// rf_wr_arb: owns the single register-file write port.
// Arbitrates pipeline writeback, a 2-entry JAL link-write queue and a
// one-deep MDU holding register; the MDU ages and eventually outranks
// the link queue, but writeback always wins.
module rf_wr_arb #(
    parameter int unsigned AGE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lnk_req,
    input  logic [29:0] lnk_pc4,
    output logic        lnk_full,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask,
    output logic        lnk_ovf
);

    localparam int unsigned AW = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

    typedef enum logic {
        MD_IDLE,
        MD_HOLD
    } md_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_LNK,
        GNT_MD
    } gnt_t;

    md_state_t   r_md_state;
    md_state_t   w_md_next;
    logic [4:0]  r_md_addr;
    logic [31:0] r_md_data;
    logic [AW-1:0] r_age;

    logic [29:0] r_q0;
    logic [29:0] r_q1;
    logic [1:0]  r_cnt;
    logic        r_ovf;

    logic        r_rf_we;
    logic [4:0]  r_rf_a3;
    logic [31:0] r_rf_wd;

    gnt_t        w_gnt;
    logic        w_wb_live;
    logic        w_lnk_live;
    logic        w_md_live;
    logic        w_md_old;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_capture;
    logic [1:0]  w_cnt_after_pop;
    logic [31:0] w_lnk_wd;
    logic [31:0] w_mask;

    // An r0 writeback is consumed here so it never claims the port.
    assign w_wb_live  = wb_we && (wb_addr != '0);
    assign w_lnk_live = (r_cnt != '0);
    assign w_md_live  = (r_md_state == MD_HOLD);
    assign w_md_old   = (r_age >= AGE_LIM);

    assign w_lnk_wd   = {r_q0 + 30'd1, 2'b00};

    assign w_pop           = (w_gnt == GNT_LNK);
    assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};
    assign w_push          = lnk_req && ((r_cnt != 2'd2) || w_pop);
    assign w_drop          = lnk_req && !w_push;

    assign md_ready  = (r_md_state == MD_IDLE);
    assign w_capture = md_valid && md_ready && (md_addr != '0);

    assign lnk_full  = (r_cnt == 2'd2);
    assign lnk_ovf   = r_ovf;
    assign rf_we     = r_rf_we;
    assign rf_a3     = r_rf_a3;
    assign rf_wd     = r_rf_wd;
    assign pend_mask = w_mask;

    // Port grant: WB, then an aged MDU, then link head, then a young MDU.
    always_comb begin
        w_gnt = GNT_NONE;
        if (w_wb_live) begin
            w_gnt = GNT_WB;
        end else if (w_md_live && w_md_old) begin
            w_gnt = GNT_MD;
        end else if (w_lnk_live) begin
            w_gnt = GNT_LNK;
        end else if (w_md_live) begin
            w_gnt = GNT_MD;
        end
    end

    // MDU holding-register next state.
    always_comb begin
        w_md_next = r_md_state;
        case (r_md_state)
            MD_IDLE: if (w_capture) w_md_next = MD_HOLD;
            MD_HOLD: if (w_gnt == GNT_MD) w_md_next = MD_IDLE;
            default: w_md_next = MD_IDLE;
        endcase
    end

    // MDU state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md_state <= MD_IDLE;
        end else begin
            r_md_state <= w_md_next;
        end
    end

    // MDU capture and saturating age counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md_addr <= '0;
            r_md_data <= '0;
            r_age     <= '0;
        end else if (w_capture) begin
            r_md_addr <= md_addr;
            r_md_data <= md_data;
            r_age     <= '0;
        end else if (w_md_live && (w_gnt != GNT_MD) && (r_age != AGE_LIM)) begin
            r_age <= r_age + 1'b1;
        end
    end

    // Link FIFO: shift on pop; a push in the same cycle lands after the shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_q0 <= r_q1;
            end
            if (w_push) begin
                if (w_cnt_after_pop == '0) begin
                    r_q0 <= lnk_pc4;
                end else begin
                    r_q1 <= lnk_pc4;
                end
            end
            r_cnt <= w_cnt_after_pop + {1'b0, w_push};
        end
    end

    // Sticky record of a dropped link push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_we <= 1'b0;
            r_rf_a3 <= '0;
            r_rf_wd <= '0;
        end else begin
            r_rf_we <= (w_gnt != GNT_NONE);
            case (w_gnt)
                GNT_WB: begin
                    r_rf_a3 <= wb_addr;
                    r_rf_wd <= wb_data;
                end
                GNT_LNK: begin
                    r_rf_a3 <= 5'd31;
                    r_rf_wd <= w_lnk_wd;
                end
                GNT_MD: begin
                    r_rf_a3 <= r_md_addr;
                    r_rf_wd <= r_md_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Pending-write scoreboard for the hazard unit.
    always_comb begin
        w_mask = '0;
        if (w_lnk_live) w_mask[31] = 1'b1;
        if (w_md_live) w_mask[r_md_addr] = 1'b1;
        w_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wr_arb.sv
// tb_rf_wr_arb: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the write-port arbiter.
module tb_rf_wr_arb;

    localparam int unsigned AGE = 4;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lnk_req;
    logic [29:0] lnk_pc4;
    logic        lnk_full;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;
    logic        lnk_ovf;

    int compared = 0;
    int mismatched = 0;

    rf_wr_arb #(.AGE_MAX(AGE)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lnk_req(lnk_req), .lnk_pc4(lnk_pc4), .lnk_full(lnk_full),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .pend_mask(pend_mask), .lnk_ovf(lnk_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int unsigned lq[$];
    bit          m_busy;
    logic [4:0]  m_a;
    logic [31:0] m_d;
    int unsigned m_age;
    bit          m_ovf;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;

    task automatic model_reset();
        lq.delete();
        m_busy = 0; m_a = '0; m_d = '0; m_age = 0; m_ovf = 0;
        e_we = 1'b0; e_a3 = '0; e_wd = '0;
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        if (lq.size() > 0) m[31] = 1'b1;
        if (m_busy) m[m_a] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Apply one clock edge worth of rules to the model.
    task automatic model_edge();
        int g;
        bit was_busy;
        was_busy = m_busy;
        if (wb_we && wb_addr != 0) g = 1;
        else if (m_busy && m_age >= AGE) g = 3;
        else if (lq.size() > 0) g = 2;
        else if (m_busy) g = 3;
        else g = 0;
        e_we = (g != 0);
        if (g == 1) begin
            e_a3 = wb_addr; e_wd = wb_data;
        end else if (g == 2) begin
            e_a3 = 5'd31; e_wd = (lq[0] + 1) << 2;
            void'(lq.pop_front());
        end else if (g == 3) begin
            e_a3 = m_a; e_wd = m_d;
        end
        if (lnk_req) begin
            if (lq.size() < 2) lq.push_back(32'(lnk_pc4));
            else m_ovf = 1;
        end
        if (g == 3) m_busy = 0;
        else if (m_busy && m_age < AGE) m_age++;
        if (!was_busy && md_valid && md_addr != 0) begin
            m_busy = 1; m_a = md_addr; m_d = md_data; m_age = 0;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lr, input logic [29:0] pc,
                         input logic mv, input logic [4:0] ma, input logic [31:0] mdat);
        @(negedge clk);
        wb_we = we; wb_addr = wa; wb_data = wd;
        lnk_req = lr; lnk_pc4 = pc;
        md_valid = mv; md_addr = ma; md_data = mdat;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wb_we = 0; wb_addr = 0; wb_data = 0; lnk_req = 0; lnk_pc4 = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        model_reset();
        #12;
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
        compared++; if (rf_a3 !== 5'd0) begin mismatched++; $display("FAIL rst_a3 got=%0d exp=0", rf_a3); end
        compared++; if (rf_wd !== 32'd0) begin mismatched++; $display("FAIL rst_wd got=%h exp=0", rf_wd); end
        compared++; if (lnk_full !== 1'b0) begin mismatched++; $display("FAIL rst_full got=%0b exp=0", lnk_full); end
        compared++; if (lnk_ovf !== 1'b0) begin mismatched++; $display("FAIL rst_ovf got=%0b exp=0", lnk_ovf); end
        compared++; if (md_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got=%0b exp=1", md_ready); end
        compared++; if (pend_mask !== 32'd0) begin mismatched++; $display("FAIL rst_mask got=%h exp=0", pend_mask); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_wb_basic();
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step();
        compared++; if (rf_we !== 1'b1) begin mismatched++; $display("FAIL wb_we got=%0b exp=1", rf_we); end
        compared++; if (rf_a3 !== 5'd5) begin mismatched++; $display("FAIL wb_a3 got=%0d exp=5", rf_a3); end
        compared++; if (rf_wd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wb_wd got=%h exp=deadbeef", rf_wd); end
        idle(1);
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL wb_idle_we got=%0b exp=0", rf_we); end
        compared++; if (rf_a3 !== 5'd5 || rf_wd !== 32'hDEADBEEF)
            begin mismatched++; $display("FAIL wb_hold got=%0d/%h exp=5/deadbeef", rf_a3, rf_wd); end
    endtask

    task automatic test_link_under_wb();
        drive(1, 3, 32'h11, 1, 30'h100, 0, 0, 0);
        step();
        compared++; if (lnk_full !== 1'b0) begin mismatched++; $display("FAIL luw_full got=%0b exp=0", lnk_full); end
        compared++; if (pend_mask[31] !== 1'b1) begin mismatched++; $display("FAIL luw_mask got=%0b exp=1", pend_mask[31]); end
        compared++; if (rf_a3 !== 5'd3) begin mismatched++; $display("FAIL luw_wb_a3 got=%0d exp=3", rf_a3); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 3, 32'h22, 0, 0, 0, 0, 0);
            step();
        end
        compared++; if (pend_mask[31] !== 1'b1) begin mismatched++; $display("FAIL luw_mask2 got=%0b exp=1", pend_mask[31]); end
        idle(1);
        compared++; if (rf_we !== 1'b1 || rf_a3 !== 5'd31)
            begin mismatched++; $display("FAIL luw_lnk_a3 got=%0b/%0d exp=1/31", rf_we, rf_a3); end
        compared++; if (rf_wd !== 32'h404) begin mismatched++; $display("FAIL luw_lnk_wd got=%h exp=00000404", rf_wd); end
        compared++; if (pend_mask[31] !== 1'b0) begin mismatched++; $display("FAIL luw_mask_clr got=%0b exp=0", pend_mask[31]); end
    endtask

    task automatic test_link_wrap();
        drive(0, 0, 0, 1, 30'h3FFFFFFF, 0, 0, 0);
        step();
        idle(1);
        compared++; if (rf_we !== 1'b1 || rf_a3 !== 5'd31 || rf_wd !== 32'h0)
            begin mismatched++; $display("FAIL wrap got=%0b/%0d/%h exp=1/31/00000000", rf_we, rf_a3, rf_wd); end
    endtask

    task automatic test_overflow();
        drive(1, 2, 32'h1, 1, 30'h10, 0, 0, 0); step();
        compared++; if (lnk_full !== 1'b0) begin mismatched++; $display("FAIL ovf_full1 got=%0b exp=0", lnk_full); end
        drive(1, 2, 32'h2, 1, 30'h20, 0, 0, 0); step();
        compared++; if (lnk_full !== 1'b1) begin mismatched++; $display("FAIL ovf_full2 got=%0b exp=1", lnk_full); end
        compared++; if (lnk_ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_early got=%0b exp=0", lnk_ovf); end
        drive(1, 2, 32'h3, 1, 30'h30, 0, 0, 0); step();
        compared++; if (lnk_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_set got=%0b exp=1", lnk_ovf); end
        idle(1);
        compared++; if (rf_wd !== 32'h44) begin mismatched++; $display("FAIL ovf_d1 got=%h exp=00000044", rf_wd); end
        idle(1);
        compared++; if (rf_wd !== 32'h84) begin mismatched++; $display("FAIL ovf_d2 got=%h exp=00000084", rf_wd); end
        idle(1);
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL ovf_dropped got=%0b exp=0", rf_we); end
        compared++; if (lnk_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got=%0b exp=1", lnk_ovf); end
    endtask

    task automatic test_mdu_vs_links();
        drive(1, 4, 32'h0, 1, 30'h200, 0, 0, 0); step();
        drive(1, 4, 32'h0, 1, 30'h300, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 7, 32'h12); step();
        compared++; if (rf_a3 !== 5'd31 || rf_wd !== 32'h804)
            begin mismatched++; $display("FAIL mvl_l1 got=%0d/%h exp=31/00000804", rf_a3, rf_wd); end
        compared++; if (md_ready !== 1'b0) begin mismatched++; $display("FAIL mvl_ready got=%0b exp=0", md_ready); end
        compared++; if (pend_mask !== 32'h8000_0080) begin mismatched++; $display("FAIL mvl_mask got=%h exp=80000080", pend_mask); end
        idle(1);
        compared++; if (rf_a3 !== 5'd31 || rf_wd !== 32'hC04)
            begin mismatched++; $display("FAIL mvl_l2 got=%0d/%h exp=31/00000c04", rf_a3, rf_wd); end
        idle(1);
        compared++; if (rf_we !== 1'b1 || rf_a3 !== 5'd7 || rf_wd !== 32'h12)
            begin mismatched++; $display("FAIL mvl_md got=%0b/%0d/%h exp=1/7/00000012", rf_we, rf_a3, rf_wd); end
        idle(1);
        compared++; if (md_ready !== 1'b1 || pend_mask !== 32'd0)
            begin mismatched++; $display("FAIL mvl_done got=%0b/%h exp=1/0", md_ready, pend_mask); end
    endtask

    task automatic test_mdu_aging();
        int got;
        got = -1;
        drive(0, 0, 0, 1, 30'h40, 1, 9, 32'h55); step();
        for (int k = 1; k <= 12 && got < 0; k++) begin
            drive(0, 0, 0, 1, 30'(32'h40 + k), 0, 0, 0); step();
            if (rf_we === 1'b1 && rf_a3 === 5'd9) got = k;
        end
        compared++; if (got != int'(AGE) + 1) begin mismatched++; $display("FAIL age_grant got=%0d exp=%0d", got, AGE + 1); end
        compared++; if (rf_wd !== 32'h55) begin mismatched++; $display("FAIL age_wd got=%h exp=00000055", rf_wd); end
        idle(4);
    endtask

    task automatic test_r0();
        drive(0, 0, 0, 0, 0, 1, 12, 32'hABC); step();
        drive(1, 0, 32'hFFFF, 0, 0, 0, 0, 0); step();
        compared++; if (rf_we !== 1'b1 || rf_a3 !== 5'd12 || rf_wd !== 32'hABC)
            begin mismatched++; $display("FAIL r0_md got=%0b/%0d/%h exp=1/12/00000abc", rf_we, rf_a3, rf_wd); end
        drive(1, 0, 32'h1234, 0, 0, 1, 0, 32'h77); step();
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL r0_wb got=%0b exp=0", rf_we); end
        compared++; if (md_ready !== 1'b1 || pend_mask !== 32'd0)
            begin mismatched++; $display("FAIL r0_mdcap got=%0b/%h exp=1/0", md_ready, pend_mask); end
        idle(1);
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL r0_md_nowrite got=%0b exp=0", rf_we); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [29:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : 30'($urandom);
            drive(($urandom_range(0, 9) < 4), 5'($urandom), $urandom,
                  ($urandom_range(0, 9) < 3), pc,
                  ($urandom_range(0, 9) < 4), 5'($urandom), $urandom);
            step();
            compared++; if (rf_we !== e_we) begin mismatched++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", c, rf_we, e_we); end
            compared++; if (rf_a3 !== e_a3) begin mismatched++; $display("FAIL rnd_a3 cyc=%0d got=%0d exp=%0d", c, rf_a3, e_a3); end
            compared++; if (rf_wd !== e_wd) begin mismatched++; $display("FAIL rnd_wd cyc=%0d got=%h exp=%h", c, rf_wd, e_wd); end
            compared++; if (lnk_full !== (lq.size() == 2)) begin mismatched++; $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", c, lnk_full, lq.size() == 2); end
            compared++; if (md_ready !== !m_busy) begin mismatched++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", c, md_ready, !m_busy); end
            compared++; if (pend_mask !== exp_mask()) begin mismatched++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", c, pend_mask, exp_mask()); end
            compared++; if (lnk_ovf !== m_ovf) begin mismatched++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", c, lnk_ovf, m_ovf); end
            compared++; if (rf_we === 1'b1 && rf_a3 === 5'd0) begin mismatched++; $display("FAIL rnd_r0write cyc=%0d got=a3 0 exp=nonzero", c); end
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        drive(1, 3, 32'h99, 1, 30'h500, 1, 6, 32'h66); step();
        drive(1, 3, 32'h98, 1, 30'h600, 0, 0, 0); step();
        compared++; if (pend_mask !== 32'h8000_0040 || rf_we !== 1'b1)
            begin mismatched++; $display("FAIL rm_pre got=%h/%0b exp=80000040/1", pend_mask, rf_we); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++; if (rf_we !== 1'b0 || rf_a3 !== 5'd0 || rf_wd !== 32'd0)
            begin mismatched++; $display("FAIL rm_port got=%0b/%0d/%h exp=0/0/0", rf_we, rf_a3, rf_wd); end
        compared++; if (lnk_full !== 1'b0 || lnk_ovf !== 1'b0 || md_ready !== 1'b1 || pend_mask !== 32'd0)
            begin mismatched++; $display("FAIL rm_state got=%0b/%0b/%0b/%h exp=0/0/1/0", lnk_full, lnk_ovf, md_ready, pend_mask); end
        @(posedge clk); #1;
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL rm_held got=%0b exp=0", rf_we); end
        @(negedge clk);
        wb_we = 0; lnk_req = 0; md_valid = 0;
        rst = 1'b1;
        model_reset();
        step();
        compared++; if (rf_we !== 1'b0 || pend_mask !== 32'd0)
            begin mismatched++; $display("FAIL rm_nowrite got=%0b/%h exp=0/0", rf_we, pend_mask); end
        drive(1, 4, 32'hCAFE, 0, 0, 0, 0, 0); step();
        compared++; if (rf_we !== 1'b1 || rf_a3 !== 5'd4 || rf_wd !== 32'hCAFE)
            begin mismatched++; $display("FAIL rm_first got=%0b/%0d/%h exp=1/4/0000cafe", rf_we, rf_a3, rf_wd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_wb_basic();
        test_link_under_wb();
        test_link_wrap();
        test_overflow();
        test_mdu_vs_links();
        test_mdu_aging();
        test_r0();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
